// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one ALU between two requesters, with a
//            single-entry tagged response buffer and saturating grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_busW,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    localparam logic [3:0] c_OP_AND  = 4'd0;
    localparam logic [3:0] c_OP_ORR  = 4'd1;
    localparam logic [3:0] c_OP_ADD  = 4'd2;
    localparam logic [3:0] c_OP_SUB  = 4'd6;
    localparam logic [3:0] c_OP_PASS = 4'd7;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [0:0]       r_state;
    logic [0:0]       w_nextState;
    logic             w_canAccept;
    logic             w_accept;
    logic             w_grantId;
    logic             r_lastGrant;
    logic             r_rspId;
    logic [WIDTH-1:0] r_rspBusW;
    logic             r_rspZero;
    logic             r_rspErr;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;
    logic [WIDTH-1:0] w_aluA;
    logic [WIDTH-1:0] w_aluB;
    logic [3:0]       w_aluCtrl;
    logic [WIDTH-1:0] w_aluRes;
    logic             w_aluErr;

    // A full buffer being drained this cycle frees its slot for a new op.
    assign w_canAccept = (r_state == S_EMPTY) || rsp_ready;

    always_comb begin
        w_accept  = 1'b0;
        w_grantId = 1'b0;
        if (w_canAccept) begin
            if (req0_valid && req1_valid) begin
                w_accept  = 1'b1;
                w_grantId = ~r_lastGrant;
            end else if (req0_valid) begin
                w_accept  = 1'b1;
                w_grantId = 1'b0;
            end else if (req1_valid) begin
                w_accept  = 1'b1;
                w_grantId = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_EMPTY: if (w_accept) w_nextState = S_FULL;
            S_FULL: begin
                if (w_accept) begin
                    w_nextState = S_FULL;
                end else if (rsp_ready) begin
                    w_nextState = S_EMPTY;
                end
            end
            default: w_nextState = S_EMPTY;
        endcase
    end

    always_comb begin
        rsp_valid  = (r_state == S_FULL);
        req0_ready = w_accept && !w_grantId;
        req1_ready = w_accept && w_grantId;
    end

    // Ungranted cycles steer req0 into the ALU; the result is simply not loaded.
    assign w_aluA    = w_grantId ? req1_a    : req0_a;
    assign w_aluB    = w_grantId ? req1_b    : req0_b;
    assign w_aluCtrl = w_grantId ? req1_ctrl : req0_ctrl;

    always_comb begin
        w_aluRes = '0;
        w_aluErr = 1'b0;
        case (w_aluCtrl)
            c_OP_AND:  w_aluRes = w_aluA & w_aluB;
            c_OP_ORR:  w_aluRes = w_aluA | w_aluB;
            c_OP_ADD:  w_aluRes = w_aluA + w_aluB;
            c_OP_SUB:  w_aluRes = w_aluA - w_aluB;
            c_OP_PASS: w_aluRes = w_aluB;
            default:   w_aluErr = 1'b1;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lastGrant <= 1'b1;
            r_rspId     <= 1'b0;
            r_rspBusW   <= '0;
            r_rspZero   <= 1'b0;
            r_rspErr    <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else if (w_accept) begin
            r_lastGrant <= w_grantId;
            r_rspId     <= w_grantId;
            r_rspBusW   <= w_aluRes;
            r_rspZero   <= !w_aluErr && (w_aluRes == '0);
            r_rspErr    <= w_aluErr;
            if (!w_grantId && (r_cnt0 != c_CNT_MAX)) r_cnt0 <= r_cnt0 + 1'b1;
            if (w_grantId && (r_cnt1 != c_CNT_MAX)) r_cnt1 <= r_cnt1 + 1'b1;
        end
    end

    assign rsp_id   = r_rspId;
    assign rsp_busW = r_rspBusW;
    assign rsp_zero = r_rspZero;
    assign rsp_err  = r_rspErr;
    assign cnt0     = r_cnt0;
    assign cnt1     = r_cnt1;

endmodule
`default_nettype wire
